// File: rtl/render_pkg.sv
// Shared render-pipeline types: fixed-point widths, vector/quaternion containers,
// rotation sequencer FSM states and the identity quaternion.
package render_pkg;
  localparam int TOTAL_PREC = 18;
  localparam int FRAC_BITS  = 13;

  typedef logic signed [2:0][TOTAL_PREC-1:0] vec3_t;
  typedef logic signed [3:0][TOTAL_PREC-1:0] quat_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rot_state_t;

  // Element 0 is the scalar w.
  localparam quat_t QUAT_IDENTITY = {{(3*TOTAL_PREC){1'b0}}, TOTAL_PREC'(1 << FRAC_BITS)};
endpackage

// File: rtl/fixed_qv.sv
// Fixed-point quaternion-vector rotation, 4-cycle latency, free-running.
// Uses v' = v + w*t + u x t with t = 2*(u x v); u = q[1..3], w = q[0].
module fixed_qv #(
  parameter int TOTAL_PREC = 18,
  parameter int FRAC_BITS  = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0][TOTAL_PREC-1:0] v,
  input  logic [3:0][TOTAL_PREC-1:0] q,
  output logic [2:0][TOTAL_PREC-1:0] res
);
  localparam int TW = TOTAL_PREC + 2;
  localparam int PW = 2*TOTAL_PREC + 4;
  localparam logic signed [PW-1:0] RND_T = PW'(1 << (FRAC_BITS-2));
  localparam logic signed [PW-1:0] RND_R = PW'(1 << (FRAC_BITS-1));

  logic signed [TOTAL_PREC-1:0] r1_v [3];
  logic signed [TOTAL_PREC-1:0] r1_q [4];
  logic signed [TW-1:0]         r2_t [3];
  logic signed [TOTAL_PREC-1:0] r2_v [3];
  logic signed [TOTAL_PREC-1:0] r2_q [4];
  logic signed [TOTAL_PREC-1:0] r3_s [3];
  logic [2:0][TOTAL_PREC-1:0]   r4_res;

  logic signed [PW-1:0] w_v [3], w_u [3], w_t [3], w_u2 [3], w_v2 [3];
  logic signed [PW-1:0] w_c1 [3], w_c2 [3];
  logic signed [PW-1:0] w_w2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_v[i]  = PW'(r1_v[i]);
      w_u[i]  = PW'(r1_q[i+1]);
      w_t[i]  = PW'(r2_t[i]);
      w_u2[i] = PW'(r2_q[i+1]);
      w_v2[i] = PW'(r2_v[i]);
    end
    w_w2 = PW'(r2_q[0]);
    for (int i = 0; i < 3; i++) begin
      w_c1[i] = w_u[(i+1)%3]*w_v[(i+2)%3] - w_u[(i+2)%3]*w_v[(i+1)%3];
      w_c2[i] = w_w2*w_t[i] + w_u2[(i+1)%3]*w_t[(i+2)%3] - w_u2[(i+2)%3]*w_t[(i+1)%3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= '{default: '0};
      r1_q   <= '{default: '0};
      r2_t   <= '{default: '0};
      r2_v   <= '{default: '0};
      r2_q   <= '{default: '0};
      r3_s   <= '{default: '0};
      r4_res <= '0;
    end else begin
      for (int i = 0; i < 4; i++) r1_q[i] <= q[i];
      r2_q <= r1_q;
      for (int i = 0; i < 3; i++) begin
        r1_v[i]   <= v[i];
        // Shift by FRAC_BITS-1 folds in the factor of two in t.
        r2_t[i]   <= TW'((w_c1[i] + RND_T) >>> (FRAC_BITS-1));
        r2_v[i]   <= r1_v[i];
        r3_s[i]   <= TOTAL_PREC'(w_v2[i] + ((w_c2[i] + RND_R) >>> FRAC_BITS));
        r4_res[i] <= r3_s[i];
      end
    end
  end

  assign res = r4_res;
endmodule

// File: rtl/rotation_seq.sv
// Handshaked packet rotator: streams NUM_VEC vectors through one shared fixed_qv.
// Optional ROTATION_SEQ_IDENTITY_BYPASS_EN short-circuits identity quaternions.
module rotation_seq #(
  parameter int TOTAL_PREC = render_pkg::TOTAL_PREC,
  parameter int FRAC_BITS  = render_pkg::FRAC_BITS,
  parameter int NUM_VEC    = 4,
  parameter int QV_LATENCY = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [NUM_VEC-1:0][2:0][TOTAL_PREC-1:0] vec_in,
  input  logic [3:0][TOTAL_PREC-1:0]              q_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [NUM_VEC-1:0][2:0][TOTAL_PREC-1:0] vec_out,
  output logic                                    busy
);
  import render_pkg::*;

  localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_VEC-1);

  rot_state_t                             r_state;
  logic [IW-1:0]                          r_idx;
  logic [NUM_VEC-1:0][2:0][TOTAL_PREC-1:0] r_vec_buf;
  logic [3:0][TOTAL_PREC-1:0]             r_q_buf;
  logic [QV_LATENCY-1:0]                  r_tag_vld;
  logic [QV_LATENCY-1:0][IW-1:0]          r_tag_idx;

  logic [2:0][TOTAL_PREC-1:0] w_res;
  logic                       w_accept, w_ident, w_tail_vld;
  logic [IW-1:0]              w_tail_idx;

  assign w_accept   = in_valid && in_ready;
  assign w_tail_vld = r_tag_vld[QV_LATENCY-1];
  assign w_tail_idx = r_tag_idx[QV_LATENCY-1];

`ifdef ROTATION_SEQ_IDENTITY_BYPASS_EN
  localparam logic [4*TOTAL_PREC-1:0] Q_ID = {{(3*TOTAL_PREC){1'b0}}, TOTAL_PREC'(1 << FRAC_BITS)};
  assign w_ident = (q_in == Q_ID);
`else
  assign w_ident = 1'b0;
`endif

  fixed_qv #(.TOTAL_PREC(TOTAL_PREC), .FRAC_BITS(FRAC_BITS)) u_qv (
    .clk  (clk),
    .rst_n(rst_n),
    .v    (r_vec_buf[r_idx]),
    .q    (r_q_buf),
    .res  (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_buf <= '0;
      r_q_buf   <= '0;
    end else if (w_accept) begin
      r_vec_buf <= vec_in;
      r_q_buf   <= q_in;
    end
  end

  // Tags ride alongside fixed_qv so only issued slots get captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      for (int i = QV_LATENCY-1; i > 0; i--) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
      r_tag_vld[0] <= (r_state == ISSUE);
      r_tag_idx[0] <= r_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  vec_out <= '0;
    else if (w_accept && w_ident) vec_out <= vec_in;
    else if (w_tail_vld)         vec_out[w_tail_idx] <= w_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          in_ready <= 1'b0;
          busy     <= 1'b1;
          r_state  <= w_ident ? DONE : ISSUE;
        end
        ISSUE: begin
          if (r_idx == LAST) begin
            r_idx   <= '0;
            r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DRAIN: if (w_tail_vld && w_tail_idx == LAST) r_state <= DONE;
        // First DONE cycle lets the final write settle before out_valid.
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rotation_seq.sv
// Directed table-driven bench for rotation_seq plus multi-cycle corner sequences.
module tb_rotation_seq;
  logic                  clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0][2:0][17:0] vec_in, vec_out;
  logic [3:0][17:0]      q_in;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ROTATION_SEQ_IDENTITY_BYPASS_EN
  localparam int ID_LAT = 1;
  localparam int ID_TOL = 0;
`else
  localparam int ID_LAT = 9;
  localparam int ID_TOL = 1;
`endif

  typedef struct {
    int v [4][3];
    int q [4];
    int e [4][3];
    int tol;
    bit ident;
  } vec_rec_t;

  vec_rec_t tbl [4];

  rotation_seq #(.TOTAL_PREC(18), .FRAC_BITS(13), .NUM_VEC(4), .QV_LATENCY(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .vec_in   (vec_in),
    .q_in     (q_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .vec_out  (vec_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_cmp++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic load(input vec_rec_t r);
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++) vec_in[i][c] = 18'(r.v[i][c]);
    for (int k = 0; k < 4; k++) q_in[k] = 18'(r.q[k]);
  endtask

  // Returns cycles from the accepting edge until out_valid is observed.
  task automatic send(input vec_rec_t r, output int lat);
    int guard;
    guard = 0;
    load(r);
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin tick; guard++; end
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin tick; lat++; end
  endtask

  task automatic check_out(input string tag, input vec_rec_t r);
    int a;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++) begin
        a = $signed(vec_out[i][c]);
        chk($sformatf("%s_v%0d_c%0d", tag, i, c), a, r.e[i][c], r.tol);
      end
  endtask

  initial begin
    int lat, bad;
    logic [3:0][2:0][17:0] snap;

    // identity
    tbl[0].v = '{'{8192,0,0}, '{0,8192,0}, '{-100,200,-300}, '{12345,-6789,42}};
    tbl[0].q = '{8192,0,0,0};
    tbl[0].e = tbl[0].v;
    tbl[0].tol = ID_TOL; tbl[0].ident = 1'b1;
    // 90 deg about z
    tbl[1].v = '{'{8192,0,0}, '{0,8192,0}, '{0,0,8192}, '{-8192,0,0}};
    tbl[1].q = '{5793,0,0,5793};
    tbl[1].e = '{'{0,8192,0}, '{-8192,0,0}, '{0,0,8192}, '{0,-8192,0}};
    tbl[1].tol = 2; tbl[1].ident = 1'b0;
    // 180 deg about x
    tbl[2].v = '{'{8192,0,0}, '{0,8192,0}, '{0,0,8192}, '{4096,4096,-4096}};
    tbl[2].q = '{0,8192,0,0};
    tbl[2].e = '{'{8192,0,0}, '{0,-8192,0}, '{0,0,-8192}, '{4096,-4096,4096}};
    tbl[2].tol = 2; tbl[2].ident = 1'b0;
    // 90 deg about x
    tbl[3].v = '{'{0,8192,0}, '{0,0,8192}, '{8192,0,0}, '{-4096,0,4096}};
    tbl[3].q = '{5793,5793,0,0};
    tbl[3].e = '{'{0,0,8192}, '{0,-8192,0}, '{8192,0,0}, '{-4096,-4096,0}};
    tbl[3].tol = 2; tbl[3].ident = 1'b0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; vec_in = '0; q_in = '0;
    tick; tick;
    chk("rst_in_ready",  int'(in_ready),  1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_busy",      int'(busy),      0, 0);
    chk("rst_vec_out",   int'(|vec_out),  0, 0);
    rst_n = 1'b1;
    tick;

    for (int t = 0; t < 4; t++) begin
      send(tbl[t], lat);
      chk($sformatf("t%0d_latency", t), lat, tbl[t].ident ? ID_LAT : 9, 0);
      check_out($sformatf("t%0d", t), tbl[t]);
      tick;
    end

    // Backpressure: DONE held with frozen outputs.
    out_ready = 1'b0;
    send(tbl[1], lat);
    chk("bp_latency", lat, 9, 0);
    snap = vec_out;
    bad = 0;
    repeat (20) begin
      tick;
      if (!out_valid || vec_out != snap || in_ready || !busy) bad++;
    end
    chk("bp_hold_violations", bad, 0, 0);
    check_out("bp", tbl[1]);
    out_ready = 1'b1;
    tick;
    chk("bp_release_out_valid", int'(out_valid), 0, 0);
    chk("bp_release_in_ready",  int'(in_ready),  1, 0);
    send(tbl[2], lat);
    chk("bp_next_latency", lat, 9, 0);
    check_out("bp_next", tbl[2]);
    tick;

    // in_valid while busy with different data must be ignored.
    load(tbl[1]);
    in_valid = 1'b1;
    tick;
    load(tbl[3]);
    chk("busy_in_ready", int'(in_ready), 0, 0);
    lat = 0;
    while (!out_valid && lat < 60) begin tick; lat++; end
    in_valid = 1'b0;
    chk("ign_latency", lat, 9, 0);
    check_out("ign", tbl[1]);
    tick;

    // Reset during DRAIN.
    load(tbl[2]);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (6) tick;
    chk("drain_busy", int'(busy), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0, 0);
    chk("mid_rst_busy",      int'(busy),      0, 0);
    chk("mid_rst_vec_out",   int'(|vec_out),  0, 0);
    tick;
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      tick;
      if (out_valid) bad++;
    end
    chk("post_rst_stale_valid", bad, 0, 0);
    send(tbl[3], lat);
    chk("post_rst_latency", lat, 9, 0);
    check_out("post_rst", tbl[3]);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rotation_seq.md
Name: rotation_seq

Overview:
Time-multiplexed, handshaked quaternion rotation engine. Accepts a packet of NUM_VEC 3-vectors (triangle vertices plus normal, or larger meshes) and one quaternion. Streams the vectors one per cycle through a single shared fixed_qv instance and returns the whole rotated packet at once. Sits between the scene/transform stage and the projection stage of the renderer. Uses one fixed_qv instead of one per vector, trading throughput for DSP count.

Parameters:
TOTAL_PREC, 18, total signed fixed-point width of every component
FRAC_BITS, 13, fractional bits (1.0 = 1<<FRAC_BITS)
NUM_VEC, 4, vectors per packet; must be >= 1
QV_LATENCY, 4, clock latency of fixed_qv from v/q to res; must match the instantiated fixed_qv

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  packet offered
in_ready  out  1  engine can accept a packet
vec_in  in  NUM_VEC x 3 x TOTAL_PREC signed  input vectors [i][x,y,z]
q_in  in  4 x TOTAL_PREC signed  quaternion; q_in[0] is the scalar w, [1..3] are x,y,z
out_valid  out  1  rotated packet available
out_ready  in  1  downstream accepts packet
vec_out  out  NUM_VEC x 3 x TOTAL_PREC signed  rotated vectors, same index order as vec_in
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, in_ready=1, out_valid=0, busy=0, vec_out all zero, counters zero.
- FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register vec_in and q_in into local buffers, go to ISSUE. in_valid is ignored in all other states (in_ready=0).
- ISSUE: issue index i, 0..NUM_VEC-1, one per cycle. Buffered vector i and buffered q drive fixed_qv. After index NUM_VEC-1, go to DRAIN.
- Capture tracking uses a QV_LATENCY-deep shift register of {valid, index} alongside fixed_qv. When the tail is valid, write res into vec_out[index]. fixed_qv has no enable and is free-running; only tagged results are stored.
- DRAIN: wait until the tag for index NUM_VEC-1 emerges and its result is written, then go to DONE.
- DONE: out_valid=1 and vec_out stable. On out_ready, go to IDLE with out_valid=0 in the next cycle. No new packet is accepted in the same cycle as out_ready (one idle cycle minimum between packets).
- Latency: out_valid rises exactly NUM_VEC+QV_LATENCY+1 cycles after the accepting edge. Throughput is one packet per NUM_VEC+QV_LATENCY+3 cycles with no backpressure.
- Arithmetic: no arithmetic beyond fixed_qv; results are passed through at TOTAL_PREC width unchanged. Index counter width is max(1,$clog2(NUM_VEC)).
- NUM_VEC=1: ISSUE lasts one cycle; counter never wraps.
- Backpressure: out_ready held low keeps DONE indefinitely with vec_out frozen.
- Reset mid-operation discards the packet and all in-flight tags; no out_valid follows.
- Inputs changing after acceptance have no effect (buffered).

Optional Feature:
ROTATION_SEQ_IDENTITY_BYPASS_EN
- Defined: if the accepted q equals (1<<FRAC_BITS,0,0,0), go IDLE -> DONE directly with vec_out = vec_in. out_valid rises 1 cycle after acceptance; fixed_qv is not used.
- Undefined: every packet takes the full pipeline path; identity gives fixed_qv's result, which may differ from the input by rounding.

Decomposition:
- Shared package render_pkg holds: fixed-point width constants (TOTAL_PREC, FRAC_BITS defaults), the typedefs vec3_t (3 x signed TOTAL_PREC) and quat_t (4 x signed), the FSM state enum rot_state_t, and the identity-quaternion constant.
- Sub-module: the existing fixed_qv, instantiated exactly once; no new sub-module.

Test Plan:
- Identity q=(8192,0,0,0), vec0=(8192,0,0) -> vec_out[0]=(8192,0,0) ±1 LSB; out_valid at cycle NUM_VEC+QV_LATENCY+1=9 after accept.
- 90 deg about z, q=(5793,0,0,5793), vectors (8192,0,0),(0,8192,0),(0,0,8192),(-8192,0,0) -> (0,8192,0),(-8192,0,0),(0,0,8192),(0,-8192,0), each ±2 LSB, index order preserved.
- out_ready low for 20 cycles in DONE -> out_valid stays 1, vec_out constant, in_ready=0; then out_ready=1 for 1 cycle -> IDLE, next packet accepted one cycle later.
- in_valid pulsed while busy with different data -> ignored; result matches the first packet only.
- rst_n low during DRAIN -> out_valid, busy, vec_out are 0 immediately; no stale out_valid after release; a fresh packet completes correctly.
- With ROTATION_SEQ_IDENTITY_BYPASS_EN defined, identity q -> out_valid 1 cycle after accept, vec_out bit-exact to vec_in; non-identity q -> normal 9-cycle latency.
